// File: rtl/serial_out_sequencer.sv
// serial_out_sequencer: streams a DATA_WIDTH word MSB byte first through a byte-wide UART TX handshake.
// Define SERIAL_OUT_NEWLINE_EN to append a CR (0x0D) and LF (0x0A) after the data bytes.
module serial_out_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  SerialOutEn,
  input  logic [DATA_WIDTH-1:0] Data,
  input  logic                  tx_done,
  output logic                  tx_start,
  output logic [7:0]            tx_byte,
  output logic                  Busy,
  output logic                  TX_flag
);
  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int CW = $clog2(NBYTES + 2);
`ifdef SERIAL_OUT_NEWLINE_EN
  localparam logic [CW-1:0] LAST = CW'(NBYTES + 1);
`else
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);
`endif
  localparam logic [CW-1:0] SHIFT_MAX = CW'(NBYTES - 1);
  typedef enum logic [2:0] {IDLE = 3'd0, SEND = 3'd1, WAIT = 3'd2, DONE = 3'd3} state_t;
  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic [CW-1:0]         r_cnt;
  logic                  r_start;
  logic                  r_busy;
  logic                  r_flag;
  logic [7:0]            w_data_byte;
  assign w_data_byte = r_shreg[DATA_WIDTH-1 -: 8];
`ifdef SERIAL_OUT_NEWLINE_EN
  localparam logic [CW-1:0] NB_C = CW'(NBYTES);
  assign tx_byte = !r_busy ? 8'h00 : r_cnt < NB_C ? w_data_byte : r_cnt == NB_C ? 8'h0D : 8'h0A;
`else
  assign tx_byte = r_busy ? w_data_byte : 8'h00;
`endif
  assign tx_start = r_start;
  assign Busy     = r_busy;
  assign TX_flag  = r_flag;
  // Outputs are registered alongside the state they belong to, so they change with the state itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_flag  <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_flag  <= 1'b0;
      case (r_state)
        IDLE: if (SerialOutEn) begin
          r_shreg <= Data;
          r_cnt   <= '0;
          r_state <= SEND;
          r_start <= 1'b1;
          r_busy  <= 1'b1;
        end
        SEND: r_state <= WAIT;
        WAIT: if (tx_done) begin
          if (r_cnt == LAST) begin
            r_state <= DONE;
            r_flag  <= 1'b1;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            if (r_cnt < SHIFT_MAX) r_shreg <= r_shreg << 8;
            r_state <= SEND;
            r_start <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/serial_out_sequencer.md
# serial_out_sequencer

Sequences a full datapath word out through the byte-wide UART transmitter on behalf of the multicycle control unit. On a one-cycle `SerialOutEn` request it latches the word, issues one transmitter start per byte, MSB byte first, waits for each byte's completion, and then returns a one-cycle `TX_flag` to the control unit. It sits between the control unit/register-file read port and the UART TX core, and owns the transmitter's start/done handshake.

## Interface
- `DATA_WIDTH`, 32, width of the word to send; must be a multiple of 8; `NBYTES = DATA_WIDTH/8`.
- `clk`  input  1  system clock, rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `SerialOutEn`  input  1  start request from the control unit; sampled only in IDLE.
- `Data`  input  DATA_WIDTH  word to transmit; sampled on the accepting edge only.
- `tx_done`  input  1  one-cycle pulse from the UART TX core: current byte fully shifted out.
- `tx_start`  output  1  one-cycle pulse to the UART TX core: load `tx_byte` and start.
- `tx_byte`  output  8  byte presented to the UART TX core; stable from SEND through WAIT.
- `Busy`  output  1  high in every state except IDLE.
- `TX_flag`  output  1  one-cycle pulse: whole word (and terminator, if configured) sent.

## Operation
- Registers: `shreg[DATA_WIDTH-1:0]`, byte counter `cnt` (wide enough for `NBYTES+1`), 3-bit state.
- States: IDLE, SEND, WAIT, DONE.
- IDLE: outputs low. If `SerialOutEn`=1: `shreg<=Data`, `cnt<=0`, go SEND. Otherwise stay.
- SEND: `tx_start`=1 for exactly this cycle. Always go WAIT.
- WAIT: hold `tx_byte`. If `tx_done`=0, stay. If `tx_done`=1 and `cnt==LAST`: go DONE. If `tx_done`=1 and `cnt<LAST`: `cnt<=cnt+1`; when `cnt<NBYTES-1`, `shreg<=shreg<<8`; go SEND.
- DONE: `TX_flag`=1 for this cycle. Always go IDLE.
- `tx_byte` = `shreg[DATA_WIDTH-1:DATA_WIDTH-8]` when `cnt<NBYTES`. Otherwise it is the terminator byte (see Configuration).
- `LAST` = `NBYTES-1`. With the macro, `LAST` = `NBYTES+1`.
- `SerialOutEn` outside IDLE is ignored. It is not queued.
- `tx_done` outside WAIT is ignored, including a `tx_done` that coincides with SEND.
- Illegal state encodings go to IDLE on the next edge.
- Reset (any time, including mid-word): state IDLE, `shreg`=0, `cnt`=0. `tx_start`, `tx_byte`, `Busy` and `TX_flag` are all 0. An aborted word produces no `TX_flag`.

## Timing
- Request accepted on edge E0. SEND occupies the cycle after E0, so the first `tx_start` is 1 cycle after the request cycle.
- Each `tx_done` sampled at edge Ek produces SEND (next `tx_start`) in the cycle after Ek. Gap between consecutive `tx_start` pulses = transmitter byte time + 1 cycle.
- Final `tx_done` sampled at edge En: `TX_flag` high in the cycle after En; IDLE one cycle later.
- Earliest next request acceptance: the IDLE cycle following DONE.
- Minimum total with immediate `tx_done`: `2*(LAST+1)+1` busy cycles. That is 9 cycles for 32-bit without the macro.
- All outputs are pure functions of registered state; no combinational path from inputs to outputs.

## Configuration
- `SERIAL_OUT_NEWLINE_EN` defined:
  - After the last data byte, two extra bytes are sent, each through its own SEND/WAIT pair: 0x0D at `cnt==NBYTES`, then 0x0A at `cnt==NBYTES+1`.
  - `TX_flag` follows the `tx_done` of 0x0A.
- Macro undefined: only the `NBYTES` data bytes are sent. No terminator logic is present.

## Test plan
- Reset with `SerialOutEn`=1 held → all outputs 0. After release, the first rising edge accepts the request and `tx_start` pulses the next cycle.
- `Data`=0x12345678, `tx_done` 5 cycles after each `tx_start` → `tx_byte` sequence 0x12, 0x34, 0x56, 0x78 with exactly four one-cycle `tx_start` pulses. `TX_flag` is a single pulse the cycle after the 4th `tx_done`.
- Same word, `Data` changed to 0xFFFFFFFF one cycle after acceptance, and `SerialOutEn` re-pulsed mid-word → bytes unchanged (0x12..0x78), still one `TX_flag`, no second transfer.
- Spurious `tx_done` in IDLE, and `tx_done` during SEND → ignored. State advances only on a `tx_done` seen in WAIT.
- Reset asserted after the 2nd `tx_done` of 0xA5A5A5A5 → immediate IDLE, outputs 0, no `TX_flag`. A new request for 0x000000FF then sends 0x00, 0x00, 0x00, 0xFF.
- With `SERIAL_OUT_NEWLINE_EN`, `Data`=0xDEADBEEF → bytes 0xDE, 0xAD, 0xBE, 0xEF, 0x0D, 0x0A. `TX_flag` comes only after the 6th `tx_done`.
